lifo_fifo_buffer: RTL and testbench
===================================

Name: lifo_fifo_buffer

Overview:
- Parametrised successor to the team's fixed-depth stack: one circular storage array serves as either a LIFO or a FIFO, selected at run time.
- Adds simultaneous push/pop, an occupancy count, a pop-valid pulse, and sticky overflow/underflow error flags.
- Sits between a producer and a consumer datapath as a general operand/token buffer.

Parameters:
- data_width, 16: bits per entry.
- data_depth, 4: number of entries; any integer >= 2 (not restricted to powers of two).
- count_width (localparam), $clog2(data_depth+1): width of the count port.

Ports:
- clock  input  1  single clock; all state updates on its rising edge.
- reset_n  input  1  asynchronous, active-low reset; asserting it clears all state immediately, independent of clock.
- mode  input  1  requested mode: 0 = LIFO, 1 = FIFO.
- push  input  1  write data_in this cycle.
- pop  input  1  read one entry this cycle.
- data_in  input  data_width  write data.
- clear_err  input  1  clears the overflow and underflow flags.
- data_out  output  data_width  registered read data; holds its value until the next successful pop.
- valid_out  output  1  one-cycle pulse: data_out was updated by a successful pop on the last edge.
- empty  output  1  high when count == 0.
- full  output  1  high when count == data_depth.
- count  output  count_width  current occupancy.
- overflow  output  1  sticky: a push was rejected.
- underflow  output  1  sticky: a pop was rejected.
- mode_active  output  1  mode currently in effect.

Behaviour:
- Reset values: data_out = 0, valid_out = 0, count = 0, empty = 1, full = 0, overflow = 0, underflow = 0, mode_active = 0 (LIFO).
- Reset also clears the head and tail pointers. Memory contents are not reset.
- Storage: memory array of data_depth entries, plus head (oldest entry) and tail (next free entry) pointers.
- Pointer arithmetic: increment wraps from data_depth-1 to 0; decrement wraps from 0 to data_depth-1.
- empty and full decode combinationally from the count register.
- Mode change: mode is sampled into mode_active only on an edge where count == 0 and push == 0 and pop == 0. Otherwise mode_active holds and the mode input is ignored.
- Push only, not full: mem[tail] <= data_in; tail++; count++.
- Push only, full: storage unchanged; overflow <= 1.
- Pop only, not empty:
  - LIFO: data_out <= mem[tail-1]; tail--.
  - FIFO: data_out <= mem[head]; head++.
  - In both modes: count--; valid_out <= 1 on that edge.
- Pop only, empty: data_out unchanged; valid_out stays 0; underflow <= 1.
- Push and pop together:
  - LIFO, any count: bypass. data_out <= data_in, valid_out <= 1; storage, pointers and count unchanged. This applies even when empty or full.
  - FIFO, count > 0: data_out <= mem[head]; mem[tail] <= data_in; head++, tail++; count unchanged; valid_out <= 1. This applies even when full.
  - FIFO, count == 0: bypass, same as the LIFO case; no underflow.
- Neither push nor pop: valid_out <= 0; all other state holds.
- Error flags:
  - clear_err clears both overflow and underflow on the edge.
  - If a set condition and clear_err occur on the same edge, set wins.
  - Flags never self-clear.
- Latency: a pop's data appears on data_out one edge after pop is sampled. count, empty and full reflect an operation after that same edge.
- reset_n asserted mid-operation: pending operations are abandoned. Outputs reach their reset values without waiting for a clock edge and hold them while reset_n = 0. The first edge after deassertion is processed normally.

Test Plan:
- LIFO, default parameters: push 0x0011, 0x0022, 0x0033; then pop x3. Required: data_out 0x0033, 0x0022, 0x0011 with valid_out pulsing each cycle; count 3 -> 0; empty = 1 at the end.
- FIFO (mode = 1 while empty): push 0x00A1..0x00A4, then push 0x00A5. Required: full = 1 and overflow = 1; pop x4 returns 0x00A1..0x00A4; pointers wrap correctly on a following push/pop of 0x00B1.
- Simultaneous push+pop:
  - FIFO, holding 0x0001, 0x0002, push 0x0003 with pop: data_out = 0x0001, count stays 2.
  - LIFO, push 0x0BEE with pop: data_out = 0x0BEE, count unchanged.
  - Both modes empty, push+pop: data_out = data_in, underflow stays 0.
- Underflow and clear: pop when empty -> underflow = 1, data_out unchanged, valid_out = 0. clear_err alone -> underflow = 0. clear_err together with another empty pop -> underflow stays 1.
- Mode lock: with count = 2, drive mode 0 -> 1. Required: mode_active stays 0 until the buffer drains to empty and an idle edge occurs, then mode_active = 1.
- Async reset: assert reset_n = 0 between edges with count = 3 and overflow = 1. Required: count = 0, empty = 1, overflow = 0, data_out = 0 before the next clock edge. After release, push 0x0055 then pop returns 0x0055.

Source files
------------

// File: rtl/lifo_fifo_buffer.sv
// rtl/lifo_fifo_buffer.sv - run-time selectable LIFO/FIFO buffer over one circular array
//
// Purpose: operand/token buffer between a producer and a consumer. One circular
// storage array with head (oldest entry) and tail (next free slot) pointers acts
// as a stack (LIFO) or a queue (FIFO). The mode is latched only while the buffer
// is empty and idle, so stored data is never reinterpreted.
//
// Ports:
//   clock        - rising-edge clock
//   reset_n      - asynchronous active-low reset
//   mode         - requested mode, 0 = LIFO, 1 = FIFO
//   push         - write data_in this cycle
//   pop          - read one entry this cycle
//   data_in      - write data
//   clear_err    - clear overflow/underflow flags
//   data_out     - registered read data, held until the next successful pop
//   valid_out    - one-cycle pulse after data_out was updated by a pop
//   empty / full - occupancy decodes of count
//   count        - current occupancy
//   overflow     - sticky, a push was rejected
//   underflow    - sticky, a pop was rejected
//   mode_active  - mode currently in effect

module lifo_fifo_buffer #(
  parameter int data_width = 16,
  parameter int data_depth = 4,
  localparam int count_width = $clog2(data_depth + 1)
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic                   mode,
  input  logic                   push,
  input  logic                   pop,
  input  logic [data_width-1:0]  data_in,
  input  logic                   clear_err,
  output logic [data_width-1:0]  data_out,
  output logic                   valid_out,
  output logic                   empty,
  output logic                   full,
  output logic [count_width-1:0] count,
  output logic                   overflow,
  output logic                   underflow,
  output logic                   mode_active
);

  localparam int ptr_width = (data_depth > 1) ? $clog2(data_depth) : 1;
  localparam logic [ptr_width-1:0]   last_ptr   = ptr_width'(data_depth - 1);
  localparam logic [count_width-1:0] full_count = count_width'(data_depth);

  // Wrapping pointer arithmetic; depth need not be a power of two.
  function automatic logic [ptr_width-1:0] ptr_inc(input logic [ptr_width-1:0] p);
    return (p == last_ptr) ? '0 : p + ptr_width'(1);
  endfunction

  function automatic logic [ptr_width-1:0] ptr_dec(input logic [ptr_width-1:0] p);
    return (p == '0) ? last_ptr : p - ptr_width'(1);
  endfunction

  logic [data_width-1:0]  r_mem [data_depth];
  logic [ptr_width-1:0]   r_head;
  logic [ptr_width-1:0]   r_tail;
  logic [count_width-1:0] r_count;
  logic [data_width-1:0]  r_data_out;
  logic                   r_valid;
  logic                   r_overflow;
  logic                   r_underflow;
  logic                   r_mode;

  logic                   w_empty;
  logic                   w_full;
  logic                   w_fifo;
  logic                   w_wr_en;
  logic                   w_mode_load;
  logic [ptr_width-1:0]   w_head_inc;
  logic [ptr_width-1:0]   w_tail_inc;
  logic [ptr_width-1:0]   w_tail_dec;

  assign w_empty    = (r_count == '0);
  assign w_full     = (r_count == full_count);
  assign w_fifo     = r_mode;
  assign w_head_inc = ptr_inc(r_head);
  assign w_tail_inc = ptr_inc(r_tail);
  assign w_tail_dec = ptr_dec(r_tail);

  // Storage is written on a plain push with room, or on a FIFO push+pop with
  // data present (a full FIFO can still accept because head advances too).
  // LIFO push+pop and empty push+pop bypass storage entirely.
  assign w_wr_en = reset_n && push &&
                   ((!pop && !w_full) || (pop && w_fifo && !w_empty));

  // Mode may only change while nothing is stored and nothing is moving.
  assign w_mode_load = w_empty && !push && !pop;

  // Memory contents are deliberately not reset.
  always_ff @(posedge clock) begin
    if (w_wr_en) begin
      r_mem[r_tail] <= data_in;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_head      <= '0;
      r_tail      <= '0;
      r_count     <= '0;
      r_data_out  <= '0;
      r_valid     <= 1'b0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
      r_mode      <= 1'b0;
    end else begin
      r_valid <= 1'b0;

      // Clear first so that a set on the same edge takes precedence.
      if (clear_err) begin
        r_overflow  <= 1'b0;
        r_underflow <= 1'b0;
      end

      if (w_mode_load) begin
        r_mode <= mode;
      end

      case ({push, pop})
        2'b10: begin
          if (w_full) begin
            r_overflow <= 1'b1;
          end else begin
            r_tail  <= w_tail_inc;
            r_count <= r_count + count_width'(1);
          end
        end
        2'b01: begin
          if (w_empty) begin
            r_underflow <= 1'b1;
          end else begin
            if (w_fifo) begin
              r_data_out <= r_mem[r_head];
              r_head     <= w_head_inc;
            end else begin
              r_data_out <= r_mem[w_tail_dec];
              r_tail     <= w_tail_dec;
            end
            r_count <= r_count - count_width'(1);
            r_valid <= 1'b1;
          end
        end
        2'b11: begin
          r_valid <= 1'b1;
          if (!w_fifo || w_empty) begin
            r_data_out <= data_in;
          end else begin
            // When full, head == tail: the read sees the old entry because
            // the memory write lands on the same edge.
            r_data_out <= r_mem[r_head];
            r_head     <= w_head_inc;
            r_tail     <= w_tail_inc;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign data_out    = r_data_out;
  assign valid_out   = r_valid;
  assign empty       = w_empty;
  assign full        = w_full;
  assign count       = r_count;
  assign overflow    = r_overflow;
  assign underflow   = r_underflow;
  assign mode_active = r_mode;

endmodule

// File: tb/tb_lifo_fifo_buffer.sv
// tb/tb_lifo_fifo_buffer.sv - testbench for lifo_fifo_buffer
module tb_lifo_fifo_buffer;

  logic        clock;
  logic        reset_n;
  logic        mode;
  logic        push;
  logic        pop;
  logic [15:0] data_in;
  logic        clear_err;
  logic [15:0] data_out;
  logic        valid_out;
  logic        empty;
  logic        full;
  logic [2:0]  count;
  logic        overflow;
  logic        underflow;
  logic        mode_active;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: a queue of stored words, back = newest.
  logic [15:0] m_q[$];
  logic        m_mode;
  logic [15:0] m_dout;
  logic        m_valid;
  logic        m_ovf;
  logic        m_unf;
  localparam int DEPTH = 4;

  lifo_fifo_buffer #(.data_width(16), .data_depth(4)) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .mode        (mode),
    .push        (push),
    .pop         (pop),
    .data_in     (data_in),
    .clear_err   (clear_err),
    .data_out    (data_out),
    .valid_out   (valid_out),
    .empty       (empty),
    .full        (full),
    .count       (count),
    .overflow    (overflow),
    .underflow   (underflow),
    .mode_active (mode_active)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic cyc(input logic p, input logic o, input logic [15:0] d, input logic c);
    push = p; pop = o; data_in = d; clear_err = c;
    @(posedge clock); #1;
    push = 1'b0; pop = 1'b0; clear_err = 1'b0;
  endtask

  task automatic model_reset();
    m_q.delete();
    m_mode = 1'b0; m_dout = 16'h0; m_valid = 1'b0; m_ovf = 1'b0; m_unf = 1'b0;
  endtask

  task automatic model_step(input logic p, input logic o, input logic [15:0] d,
                            input logic md, input logic c);
    bit set_o = 0;
    bit set_u = 0;
    bit idle_empty = (m_q.size() == 0) && !p && !o;
    m_valid = 1'b0;
    if (p && o) begin
      m_valid = 1'b1;
      if (!m_mode || m_q.size() == 0) m_dout = d;
      else begin m_dout = m_q.pop_front(); m_q.push_back(d); end
    end else if (p) begin
      if (m_q.size() == DEPTH) set_o = 1; else m_q.push_back(d);
    end else if (o) begin
      if (m_q.size() == 0) set_u = 1;
      else begin
        m_valid = 1'b1;
        m_dout = m_mode ? m_q.pop_front() : m_q.pop_back();
      end
    end
    if (c) begin m_ovf = 1'b0; m_unf = 1'b0; end
    if (set_o) m_ovf = 1'b1;
    if (set_u) m_unf = 1'b1;
    if (idle_empty) m_mode = md;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; mode = 1'b0; push = 0; pop = 0; data_in = 0; clear_err = 0;
    repeat (2) @(posedge clock);
    #1;
    n_checks++; if (data_out !== 16'h0) $display("FAIL reset_data_out got=%h exp=0000", data_out); else n_pass++;
    n_checks++; if (valid_out !== 1'b0) $display("FAIL reset_valid got=%b exp=0", valid_out); else n_pass++;
    n_checks++; if (count !== 3'd0 || empty !== 1'b1 || full !== 1'b0) $display("FAIL reset_occupancy count=%0d empty=%b full=%b exp 0/1/0", count, empty, full); else n_pass++;
    n_checks++; if (overflow !== 1'b0 || underflow !== 1'b0) $display("FAIL reset_flags ovf=%b unf=%b exp 0/0", overflow, underflow); else n_pass++;
    n_checks++; if (mode_active !== 1'b0) $display("FAIL reset_mode got=%b exp=0", mode_active); else n_pass++;
    reset_n = 1'b1;
  endtask

  task automatic test_lifo();
    cyc(1, 0, 16'h0011, 0); cyc(1, 0, 16'h0022, 0); cyc(1, 0, 16'h0033, 0);
    n_checks++; if (count !== 3'd3) $display("FAIL lifo_count3 got=%0d exp=3", count); else n_pass++;
    cyc(0, 1, 16'h0, 0);
    n_checks++; if (data_out !== 16'h0033 || valid_out !== 1'b1 || count !== 3'd2) $display("FAIL lifo_pop1 data=%h v=%b cnt=%0d exp 0033/1/2", data_out, valid_out, count); else n_pass++;
    cyc(0, 1, 16'h0, 0);
    n_checks++; if (data_out !== 16'h0022 || valid_out !== 1'b1 || count !== 3'd1) $display("FAIL lifo_pop2 data=%h v=%b cnt=%0d exp 0022/1/1", data_out, valid_out, count); else n_pass++;
    cyc(0, 1, 16'h0, 0);
    n_checks++; if (data_out !== 16'h0011 || valid_out !== 1'b1 || count !== 3'd0 || empty !== 1'b1) $display("FAIL lifo_pop3 data=%h v=%b cnt=%0d empty=%b exp 0011/1/0/1", data_out, valid_out, count, empty); else n_pass++;
    cyc(0, 0, 16'h0, 0);
    n_checks++; if (valid_out !== 1'b0 || data_out !== 16'h0011) $display("FAIL lifo_idle v=%b data=%h exp 0/0011", valid_out, data_out); else n_pass++;
  endtask

  task automatic test_fifo_overflow();
    mode = 1'b1;
    cyc(0, 0, 16'h0, 0);
    n_checks++; if (mode_active !== 1'b1) $display("FAIL fifo_mode got=%b exp=1", mode_active); else n_pass++;
    for (int i = 1; i <= 4; i++) cyc(1, 0, 16'h00A0 + 16'(i), 0);
    n_checks++; if (full !== 1'b1 || count !== 3'd4 || overflow !== 1'b0) $display("FAIL fifo_full full=%b cnt=%0d ovf=%b exp 1/4/0", full, count, overflow); else n_pass++;
    cyc(1, 0, 16'h00A5, 0);
    n_checks++; if (overflow !== 1'b1 || full !== 1'b1 || count !== 3'd4) $display("FAIL fifo_overflow ovf=%b full=%b cnt=%0d exp 1/1/4", overflow, full, count); else n_pass++;
    for (int i = 1; i <= 4; i++) begin
      cyc(0, 1, 16'h0, 0);
      n_checks++; if (data_out !== 16'h00A0 + 16'(i) || valid_out !== 1'b1) $display("FAIL fifo_pop%0d data=%h v=%b exp %h/1", i, data_out, valid_out, 16'h00A0 + 16'(i)); else n_pass++;
    end
    cyc(1, 0, 16'h00B1, 0);
    cyc(0, 1, 16'h0, 0);
    n_checks++; if (data_out !== 16'h00B1 || empty !== 1'b1) $display("FAIL fifo_wrap data=%h empty=%b exp 00b1/1", data_out, empty); else n_pass++;
    n_checks++; if (overflow !== 1'b1) $display("FAIL fifo_ovf_sticky got=%b exp=1", overflow); else n_pass++;
    cyc(0, 0, 16'h0, 1);
    n_checks++; if (overflow !== 1'b0) $display("FAIL fifo_ovf_clear got=%b exp=0", overflow); else n_pass++;
  endtask

  task automatic test_simultaneous();
    cyc(1, 0, 16'h0001, 0); cyc(1, 0, 16'h0002, 0);
    cyc(1, 1, 16'h0003, 0);
    n_checks++; if (data_out !== 16'h0001 || count !== 3'd2 || valid_out !== 1'b1) $display("FAIL fifo_pushpop data=%h cnt=%0d v=%b exp 0001/2/1", data_out, count, valid_out); else n_pass++;
    cyc(0, 1, 16'h0, 0); cyc(0, 1, 16'h0, 0);
    n_checks++; if (data_out !== 16'h0003 || empty !== 1'b1) $display("FAIL fifo_pushpop_drain data=%h empty=%b exp 0003/1", data_out, empty); else n_pass++;
    cyc(1, 1, 16'h1234, 0);
    n_checks++; if (data_out !== 16'h1234 || underflow !== 1'b0 || count !== 3'd0) $display("FAIL fifo_empty_bypass data=%h unf=%b cnt=%0d exp 1234/0/0", data_out, underflow, count); else n_pass++;
    mode = 1'b0;
    cyc(0, 0, 16'h0, 0);
    n_checks++; if (mode_active !== 1'b0) $display("FAIL lifo_mode got=%b exp=0", mode_active); else n_pass++;
    cyc(1, 0, 16'h0AAA, 0);
    cyc(1, 1, 16'h0BEE, 0);
    n_checks++; if (data_out !== 16'h0BEE || count !== 3'd1 || valid_out !== 1'b1) $display("FAIL lifo_pushpop data=%h cnt=%0d v=%b exp 0bee/1/1", data_out, count, valid_out); else n_pass++;
    cyc(0, 1, 16'h0, 0);
    n_checks++; if (data_out !== 16'h0AAA) $display("FAIL lifo_pushpop_storage data=%h exp 0aaa", data_out); else n_pass++;
    cyc(1, 1, 16'h4321, 0);
    n_checks++; if (data_out !== 16'h4321 || underflow !== 1'b0) $display("FAIL lifo_empty_bypass data=%h unf=%b exp 4321/0", data_out, underflow); else n_pass++;
  endtask

  task automatic test_underflow();
    cyc(0, 1, 16'h0, 0);
    n_checks++; if (underflow !== 1'b1 || data_out !== 16'h4321 || valid_out !== 1'b0) $display("FAIL underflow_set unf=%b data=%h v=%b exp 1/4321/0", underflow, data_out, valid_out); else n_pass++;
    cyc(0, 0, 16'h0, 1);
    n_checks++; if (underflow !== 1'b0) $display("FAIL underflow_clear got=%b exp=0", underflow); else n_pass++;
    cyc(0, 1, 16'h0, 1);
    n_checks++; if (underflow !== 1'b1) $display("FAIL underflow_set_wins got=%b exp=1", underflow); else n_pass++;
    cyc(0, 0, 16'h0, 1);
  endtask

  task automatic test_mode_lock();
    cyc(1, 0, 16'h00C1, 0); cyc(1, 0, 16'h00C2, 0);
    mode = 1'b1;
    cyc(0, 0, 16'h0, 0);
    n_checks++; if (mode_active !== 1'b0) $display("FAIL mode_lock_hold got=%b exp=0", mode_active); else n_pass++;
    cyc(0, 1, 16'h0, 0);
    n_checks++; if (data_out !== 16'h00C2 || mode_active !== 1'b0) $display("FAIL mode_lock_lifo data=%h mode=%b exp 00c2/0", data_out, mode_active); else n_pass++;
    cyc(0, 1, 16'h0, 0);
    n_checks++; if (mode_active !== 1'b0 || empty !== 1'b1) $display("FAIL mode_lock_drain mode=%b empty=%b exp 0/1", mode_active, empty); else n_pass++;
    cyc(0, 0, 16'h0, 0);
    n_checks++; if (mode_active !== 1'b1) $display("FAIL mode_lock_release got=%b exp=1", mode_active); else n_pass++;
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 5; i++) cyc(1, 0, 16'h00D0 + 16'(i), 0);
    cyc(0, 1, 16'h0, 0);
    n_checks++; if (count !== 3'd3 || overflow !== 1'b1) $display("FAIL areset_setup cnt=%0d ovf=%b exp 3/1", count, overflow); else n_pass++;
    #2 reset_n = 1'b0;
    #1;
    n_checks++; if (count !== 3'd0 || empty !== 1'b1 || overflow !== 1'b0 || data_out !== 16'h0) $display("FAIL areset_immediate cnt=%0d empty=%b ovf=%b data=%h exp 0/1/0/0000", count, empty, overflow, data_out); else n_pass++;
    @(posedge clock); #1;
    n_checks++; if (count !== 3'd0 || mode_active !== 1'b0) $display("FAIL areset_hold cnt=%0d mode=%b exp 0/0", count, mode_active); else n_pass++;
    mode = 1'b0;
    reset_n = 1'b1;
    cyc(1, 0, 16'h0055, 0);
    cyc(0, 1, 16'h0, 0);
    n_checks++; if (data_out !== 16'h0055 || valid_out !== 1'b1) $display("FAIL areset_after data=%h v=%b exp 0055/1", data_out, valid_out); else n_pass++;
  endtask

  task automatic test_random();
    logic p, o, c;
    logic [15:0] d;
    reset_n = 1'b0; mode = 1'b0;
    #2 reset_n = 1'b1;
    model_reset();
    for (int i = 0; i < 400; i++) begin
      p = 1'($urandom_range(0, 1));
      o = 1'($urandom_range(0, 1));
      c = ($urandom_range(0, 7) == 0);
      d = 16'($urandom);
      if ($urandom_range(0, 5) == 0) mode = ~mode;
      model_step(p, o, d, mode, c);
      cyc(p, o, d, c);
      n_checks++; if (data_out !== m_dout) $display("FAIL rand_data step=%0d got=%h exp=%h", i, data_out, m_dout); else n_pass++;
      n_checks++; if (valid_out !== m_valid) $display("FAIL rand_valid step=%0d got=%b exp=%b", i, valid_out, m_valid); else n_pass++;
      n_checks++; if (count !== 3'(m_q.size())) $display("FAIL rand_count step=%0d got=%0d exp=%0d", i, count, m_q.size()); else n_pass++;
      n_checks++; if (empty !== (m_q.size() == 0) || full !== (m_q.size() == DEPTH)) $display("FAIL rand_flags step=%0d empty=%b full=%b size=%0d", i, empty, full, m_q.size()); else n_pass++;
      n_checks++; if (overflow !== m_ovf || underflow !== m_unf) $display("FAIL rand_err step=%0d ovf=%b unf=%b exp %b/%b", i, overflow, underflow, m_ovf, m_unf); else n_pass++;
      n_checks++; if (mode_active !== m_mode) $display("FAIL rand_mode step=%0d got=%b exp=%b", i, mode_active, m_mode); else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_lifo();
    test_fifo_overflow();
    test_simultaneous();
    test_underflow();
    test_mode_lock();
    test_async_reset();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
